// File: rtl/frog_game_ctrl.sv
// frog_game_ctrl: frog game state controller. Conditions the four direction
// buttons, moves the frog one cell per frame, and runs the play / dead / win /
// game-over sequencing that drives the display's frog, lives and score.
module frog_game_ctrl #(
  parameter int COLS           = 20,
  parameter int ROWS           = 15,
  parameter int START_COL      = 10,
  parameter int START_ROW      = 14,
  parameter int LIVES_INIT     = 3,
  parameter int DEBOUNCE_CYC   = 250000,
  parameter int RESPAWN_FRAMES = 60,
  parameter int WIN_FRAMES     = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       frame_tick,
  input  logic       car_hit,
  output logic [4:0] frog_col,
  output logic [3:0] frog_row,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic       frog_visible,
  output logic       game_over
);

  localparam int              DB_W         = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST      = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [DB_W-1:0] DB_ONE       = DB_W'(1);
  localparam logic [4:0]      COL_MAX      = 5'(COLS - 1);
  localparam logic [3:0]      ROW_MAX      = 4'(ROWS - 1);
  localparam logic [4:0]      SPAWN_COL    = 5'(START_COL);
  localparam logic [3:0]      SPAWN_ROW    = 4'(START_ROW);
  localparam logic [1:0]      LIVES_RST    = 2'(LIVES_INIT);
  localparam logic [5:0]      RESPAWN_LAST = 6'(RESPAWN_FRAMES - 1);
  localparam logic [5:0]      WIN_LAST     = 6'(WIN_FRAMES - 1);

  // Button / direction index: 0 up, 1 down, 2 left, 3 right (also the priority order).
  localparam logic [1:0] DIR_UP   = 2'd0;
  localparam logic [1:0] DIR_DOWN = 2'd1;
  localparam logic [1:0] DIR_LEFT = 2'd2;

  typedef enum logic [1:0] {PLAY, DEAD, WIN, GAME_OVER} state_t;

  state_t          state, state_next;
  logic [3:0]      btn_raw, sync1, sync2, stable, flip, press;
  logic [DB_W-1:0] db_cnt [4];
  logic            any_press;
  logic [1:0]      press_dir;
  logic            pend_valid, pend_valid_next;
  logic [1:0]      pend_dir, pend_dir_next;
  logic [4:0]      col_next;
  logic [3:0]      row_next;
  logic [1:0]      lives_next;
  logic [7:0]      score_next;
  logic [5:0]      frame_cnt, frame_cnt_next;

  assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

  // Two-flop synchronizer for the asynchronous buttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // A button flips once it has disagreed with its stable value for DEBOUNCE_CYC cycles;
  // a flip towards 1 is a press event.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      flip[i] = (sync2[i] != stable[i]) && (db_cnt[i] == DB_LAST);
    end
    press = flip & sync2;
  end

  // Debounce counters restart whenever the synchronized input agrees with the stable value.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (flip[i]) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_ONE;
        end
      end
    end
  end

  // Simultaneous presses resolve up > down > left > right.
  always_comb begin
    any_press = |press;
    press_dir = DIR_UP;
    if (press[0])      press_dir = 2'd0;
    else if (press[1]) press_dir = 2'd1;
    else if (press[2]) press_dir = 2'd2;
    else if (press[3]) press_dir = 2'd3;
  end

  // State and game registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PLAY;
      frog_col   <= SPAWN_COL;
      frog_row   <= SPAWN_ROW;
      lives      <= LIVES_RST;
      score      <= '0;
      frame_cnt  <= '0;
      pend_valid <= 1'b0;
      pend_dir   <= DIR_UP;
    end else begin
      state      <= state_next;
      frog_col   <= col_next;
      frog_row   <= row_next;
      lives      <= lives_next;
      score      <= score_next;
      frame_cnt  <= frame_cnt_next;
      pend_valid <= pend_valid_next;
      pend_dir   <= pend_dir_next;
    end
  end

  // Next-state and datapath: everything advances on frame ticks, except the
  // game-over restart, which fires on the press event itself.
  always_comb begin
    state_next      = state;
    col_next        = frog_col;
    row_next        = frog_row;
    lives_next      = lives;
    score_next      = score;
    frame_cnt_next  = frame_cnt;
    pend_valid_next = 1'b0;
    pend_dir_next   = pend_dir;
    case (state)
      PLAY: begin
        pend_valid_next = pend_valid;
        if (frame_tick && car_hit) begin
          // Collision wins over any pending move.
          if (lives != 2'd0) lives_next = lives - 2'd1;
          pend_valid_next = 1'b0;
          frame_cnt_next  = '0;
          state_next      = DEAD;
        end else if (frame_tick) begin
          pend_valid_next = 1'b0;
          if (pend_valid) begin
            case (pend_dir)
              DIR_UP:   if (frog_row != 4'd0)    row_next = frog_row - 4'd1;
              DIR_DOWN: if (frog_row != ROW_MAX) row_next = frog_row + 4'd1;
              DIR_LEFT: if (frog_col != 5'd0)    col_next = frog_col - 5'd1;
              default:  if (frog_col != COL_MAX) col_next = frog_col + 5'd1;
            endcase
          end
          if (row_next == 4'd0) begin
            score_next     = score + 8'd1;
            frame_cnt_next = '0;
            state_next     = WIN;
          end else if (any_press) begin
            // A press on the tick cycle belongs to the frame that starts now.
            pend_valid_next = 1'b1;
            pend_dir_next   = press_dir;
          end
        end else if (any_press && !pend_valid) begin
          pend_valid_next = 1'b1;
          pend_dir_next   = press_dir;
        end
      end
      DEAD: begin
        if (frame_tick) begin
          frame_cnt_next = frame_cnt + 6'd1;
          if (frame_cnt == RESPAWN_LAST) begin
            frame_cnt_next = '0;
            if (lives == 2'd0) begin
              state_next = GAME_OVER;
            end else begin
              col_next   = SPAWN_COL;
              row_next   = SPAWN_ROW;
              state_next = PLAY;
            end
          end
        end
      end
      WIN: begin
        if (frame_tick) begin
          frame_cnt_next = frame_cnt + 6'd1;
          if (frame_cnt == WIN_LAST) begin
            frame_cnt_next = '0;
            col_next       = SPAWN_COL;
            row_next       = SPAWN_ROW;
            state_next     = PLAY;
          end
        end
      end
      default: begin
        if (any_press) begin
          lives_next     = LIVES_RST;
          score_next     = '0;
          col_next       = SPAWN_COL;
          row_next       = SPAWN_ROW;
          frame_cnt_next = '0;
          state_next     = PLAY;
        end
      end
    endcase
  end

  // Outputs decoded from registered state: blink every 8 frames while dead.
  always_comb begin
    frog_visible = 1'b1;
    game_over    = 1'b0;
    if (state == DEAD)      frog_visible = ~frame_cnt[3];
    if (state == GAME_OVER) game_over    = 1'b1;
  end

endmodule

// File: doc/frog_game_ctrl.md
# frog_game_ctrl

Game-state controller for the frog game: debounces the four direction buttons, moves the frog one grid cell per frame, handles car collisions, lives, respawn, goal scoring and game-over/restart. It is the writer of the state that the VGA display renders. Its `frog_col`, `frog_row` and `lives` outputs drive the display's frog and lives inputs directly. `frame_tick` comes from the display timing (one pulse per frame). `car_hit` comes from the car/frog cell comparator.

## Interface

Parameters:
- `COLS`, 20: grid columns (640/32); legal `frog_col` range is 0..COLS-1.
- `ROWS`, 15: grid rows (480/32); legal `frog_row` range is 0..ROWS-1.
- `START_COL`, 10: spawn column.
- `START_ROW`, 14: spawn row (bottom).
- `LIVES_INIT`, 3: lives at reset and restart.
- `DEBOUNCE_CYC`, 250000: stable cycles required to accept a button change (10 ms at 25 MHz).
- `RESPAWN_FRAMES`, 60: frames spent in DEAD.
- `WIN_FRAMES`, 30: frames spent in WIN.

Ports:
- `clk`, in, 1: pixel clock. Single clock domain.
- `rst`, in, 1: synchronous reset, active-high.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, in, 1 each: raw asynchronous buttons, active-high.
- `frame_tick`, in, 1: one-cycle pulse once per frame.
- `car_hit`, in, 1: high while any car occupies the frog's current cell.
- `frog_col`, out, 5: frog column.
- `frog_row`, out, 4: frog row.
- `lives`, out, 2: remaining lives.
- `score`, out, 8: goals reached. Wraps 255 to 0.
- `frog_visible`, out, 1: low during the DEAD blink phases.
- `game_over`, out, 1: high in the GAME_OVER state.

## Operation

**Button conditioning**
- Each button passes through a 2-FF synchronizer, then a debouncer.
- The debouncer's stable value flips only after the synchronized input differs from it for DEBOUNCE_CYC consecutive cycles.
- A press event is a 0→1 transition of the stable value.

**Pending move**
- A press event in PLAY sets the pending-move register, unless a move is already pending; a second press within the same frame is dropped.
- If several press events occur in the same cycle, priority is up > down > left > right.
- Outside PLAY, press events do not set a pending move, and any pending move is cleared on leaving PLAY.

**State machine**: PLAY, DEAD, WIN, GAME_OVER. Reset state is PLAY.

PLAY, on `frame_tick`:
- If `car_hit` is high:
  - lives ← lives−1, saturating at 0.
  - Clear the pending move.
  - Frame counter ← 0.
  - Go to DEAD.
- Otherwise, apply the pending move and clear it:
  - Up: row−1.
  - Down: row+1.
  - Left: col−1.
  - Right: col+1.
  - Clamp: a move past 0 or past COLS-1/ROWS-1 leaves the coordinate unchanged.
  - If the new row is 0: score+1, frame counter ← 0, go to WIN.
- Collision wins over move: a frame with `car_hit` high never applies a move.

DEAD:
- On each `frame_tick`, frame counter +1.
- `frog_visible` = NOT counter[3], so visibility toggles every 8 frames.
- When the counter reaches RESPAWN_FRAMES−1 on a tick:
  - If lives is 0: go to GAME_OVER.
  - Otherwise: frog ← (START_COL, START_ROW), `frog_visible` ← 1, go to PLAY.
- The frog position is held at the collision cell throughout DEAD.

WIN:
- Counts WIN_FRAMES frame ticks, frog held at row 0.
- Then frog ← spawn position, go to PLAY. Lives are unchanged.

GAME_OVER:
- `game_over` = 1, `frog_visible` = 1, frog held at its position.
- Any press event restarts the game:
  - lives ← LIVES_INIT, score ← 0.
  - frog ← spawn position.
  - Go to PLAY.
- The restart happens on that press event's cycle; no `frame_tick` is needed.

**Reset values**
- `frog_col` = START_COL, `frog_row` = START_ROW.
- `lives` = LIVES_INIT, `score` = 0.
- `frog_visible` = 1, `game_over` = 0.
- State PLAY, no move pending, debouncers stable at 0, frame counter 0.

## Timing

- All outputs are registered and change only on the clk edge that samples a `frame_tick` high, or a GAME_OVER press event.
- Latency from raw button to press event: 2 synchronizer cycles + DEBOUNCE_CYC, with a tolerance of ±1 cycle.
- The move is visible on the output the cycle after the next `frame_tick`. At most one move per frame.
- `car_hit` is sampled only in the `frame_tick` cycle; glitches between ticks are ignored.
- `rst` asserted in any state or mid-debounce restores the reset values on the next edge, overriding `frame_tick` and press events in the same cycle.
- The frame counter is 6 bits wide; RESPAWN_FRAMES and WIN_FRAMES must not exceed 64.

## Test plan

All scenarios use DEBOUNCE_CYC=4 and `frame_tick` every 20 cycles.

1. **Reset:** assert `rst` 2 cycles → col=10, row=14, lives=3, score=0, frog_visible=1, game_over=0.
2. **Move and bounce rejection:**
   - Hold btn_up 10 cycles, then one tick → row=13 one cycle after the tick, col=10.
   - A 2-cycle btn_left pulse → no move.
3. **Clamping and per-frame limit:**
   - Press right 12 times across frames → col saturates at 19.
   - Press down at row 14 → row stays 14.
   - Two presses within one frame → only one move.
4. **Collision:**
   - `car_hit`=1 on a tick with a pending up press → lives 3→2, row unchanged.
   - frog_visible low during frames 8–15 of DEAD.
   - After 60 ticks → spawn position (10, 14), PLAY.
5. **Goal:** drive the frog to row 0 → score=1, WIN, respawn at (10, 14) after 30 ticks with lives unchanged.
6. **Game over and restart:**
   - Three collisions → lives=0, and game_over=1 after the DEAD delay.
   - A btn_left press → lives=3, score=0, spawn position, game_over=0.
   - `rst` mid-DEAD → reset values on the next edge.
